instr_encode: RTL and testbench
===============================

# instr_encode

Packs decoded RISC-V RV32I instruction fields (opcode, register indices, funct fields, full-width immediate) back into 32-bit instruction words; it is the inverse of the core's instruction decoder. Used by the self-test program generator and the debug instruction injector to feed the fetch path. Requests and results use valid/ready handshakes with a registered output. With the pseudo-op feature compiled in, one `li` request expands into a multi-word LUI/ADDI sequence.

## Interface
Parameters: none.

- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous and active-high
- valid_i  in  1  request valid
- ready_o  out  1  request accepted when valid_i && ready_o
- fmt_i  in  3  fmt_e: FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtLi
- opcode_i  in  7  major opcode; ignored for FmtLi
- rd_i, rs1_i, rs2_i  in  5 each  register indices
- funct3_i  in  3  funct3
- funct7_i  in  7  funct7; FmtR only
- imm_i  in  32  signed byte-offset or value, same form the decoder produces
- valid_o  out  1  output word valid
- ready_i  in  1  consumer ready; a word transfers when valid_o && ready_i
- instr_o  out  32  encoded word
- last_o  out  1  final word of the current request
- err_o  out  1  request illegal; instr_o is NOP 32'h00000013

## Operation
- States: IDLE (output empty), OUT (single or final word held), OUT_HI (LUI word of a 2-word li held, ADDI word pending).
- Field placement follows RV32I formats R/I/S/B/U/J exactly.
  - B/J use imm[12:1] and imm[20:1] respectively.
  - U uses imm[31:12].
  - I-type shifts take funct7 through imm[11:5].
- Range checks, evaluated at accept. On failure: emit one NOP word, err_o=1, last_o=1.
  - I and S: −2048..2047.
  - B: −4096..4094, and imm[0] must be 0.
  - J: −1048576..1048574, and imm[0] must be 0.
  - U: imm[11:0] must be 0.
  - Any fmt_i value outside the enum is illegal.
- li expansion: hi = (imm_i + 32'h800) >> 12 (mod 2^32); lo = imm_i[11:0].
  - hi==0: emit ADDI rd,x0,lo (1 word).
  - lo==0: emit LUI rd,hi (1 word).
  - Otherwise: LUI rd,hi, then ADDI rd,rd,lo.
- err_o and last_o are registered with instr_o and are meaningful only while valid_o=1.

## Timing
- Reset (asynchronous): state=IDLE, valid_o=0, instr_o=0, last_o=0, err_o=0.
- Accept to valid_o: 1 cycle. Single-word throughput is 1 request/cycle under continuous ready_i.
- ready_o = (state==IDLE) || (state==OUT && ready_i). It is combinational from state and ready_i and never depends on valid_i.
- OUT_HI forces ready_o=0. On transfer of the LUI word, the ADDI word loads the next cycle (state OUT, last_o=1). A 2-word li occupies 2 output beats with no bubble when ready_i stays high.
- While valid_o && !ready_i: instr_o, last_o and err_o hold stable, and valid_o does not drop.
- Transfer in OUT with no new accept: next state IDLE, valid_o=0.
- Reset asserted mid-sequence (e.g. in OUT_HI): the pending ADDI is discarded and the next word after reset comes from a new request.

## Configuration
- ENCODE_PSEUDO_EN defined: FmtLi is supported as described, including OUT_HI.
- ENCODE_PSEUDO_EN undefined: OUT_HI is not built and FmtLi is illegal (NOP, err_o=1, last_o=1).
- All other behaviour is identical in both builds.

## Structure
- Shared package riscv_pkg holds:
  - opcode_e, shared with the decoder.
  - fmt_e.
  - localparam NOP = 32'h00000013.
  - Immediate range constants.
- Sub-module instr_pack is purely combinational: fields plus fmt in, 32-bit word plus range-error out. It is instantiated once.
- The FSM in instr_encode muxes the fields into instr_pack: request fields, or the synthesized LUI/ADDI fields.

## Test plan
- add x3,x1,x2: FmtR, opcode 0110011, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> instr_o=0x002081B3, last_o=1, err_o=0, one cycle after accept.
- addi x1,x0,−1 (FmtI, imm=0xFFFFFFFF) -> 0xFFF00093. beq x0,x0,−4 (FmtB, imm=−4) -> 0xFE000EE3.
- li x5,0x12345FFF with ready_i held high:
  - Beat 1: 0x123462B7, last_o=0.
  - Beat 2: 0xFFF28293, last_o=1.
  - ready_o=0 during beat 1.
  - li x5,0x800 -> hi=1, lo=0x800 -> 0x000012B7 then 0x80028293.
  - Without ENCODE_PSEUDO_EN: a single NOP with err_o=1.
- FmtI imm=2048, and FmtB imm=5 -> each emits 0x00000013, err_o=1, last_o=1.
- Backpressure: ready_i=0 for 3 cycles after valid_o rises -> instr_o, last_o and valid_o stable, ready_o=0. Release gives exactly one transfer, with no duplicate and no drop.
- Reset pulse during OUT_HI of li -> valid_o=0 immediately and the ADDI word is never emitted. A following addi request is encoded correctly one cycle after accept.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encode/decode types: opcodes, encoder formats, NOP and
// immediate range limits.
package riscv_pkg;

  typedef enum logic [6:0] {
    OpLoad   = 7'b0000011,
    OpFence  = 7'b0001111,
    OpImm    = 7'b0010011,
    OpAuipc  = 7'b0010111,
    OpStore  = 7'b0100011,
    OpReg    = 7'b0110011,
    OpLui    = 7'b0110111,
    OpBranch = 7'b1100011,
    OpJalr   = 7'b1100111,
    OpJal    = 7'b1101111,
    OpSystem = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    FmtR  = 3'd0,
    FmtI  = 3'd1,
    FmtS  = 3'd2,
    FmtB  = 3'd3,
    FmtU  = 3'd4,
    FmtJ  = 3'd5,
    FmtLi = 3'd6
  } fmt_e;

  localparam logic [31:0] NOP = 32'h00000013;

  localparam int ImmIMin = -2048;
  localparam int ImmIMax = 2047;
  localparam int ImmBMin = -4096;
  localparam int ImmBMax = 4094;
  localparam int ImmJMin = -1048576;
  localparam int ImmJMax = 1048574;

  function automatic logic in_range(
    input logic [31:0] v,
    input int          lo,
    input int          hi
  );
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_encode_if.sv
// Request/response bundle of the instruction encoder.
// slave = encoder side, master = requester/consumer side.
interface instr_encode_if;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  fmt_i;
  logic [6:0]  opcode_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] imm_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic        last_o;
  logic        err_o;

  modport slave (
    input  valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i,
    input  funct3_i, funct7_i, imm_i, ready_i,
    output ready_o, valid_o, instr_o, last_o, err_o
  );

  modport master (
    output valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i,
    output funct3_i, funct7_i, imm_i, ready_i,
    input  ready_o, valid_o, instr_o, last_o, err_o
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with immediate range checking.
// Illegal formats or out-of-range immediates yield NOP with err_o=1.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_o
);
  logic [31:0] raw;
  logic        bad;

  always_comb begin
    raw = NOP;
    bad = 1'b1;
    unique case (fmt_i)
      FmtR: begin
        raw = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        bad = 1'b0;
      end
      FmtI: begin
        raw = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        bad = !in_range(imm_i, ImmIMin, ImmIMax);
      end
      FmtS: begin
        raw = {imm_i[11:5], rs2_i, rs1_i, funct3_i,
               imm_i[4:0], opcode_i};
        bad = !in_range(imm_i, ImmIMin, ImmIMax);
      end
      FmtB: begin
        raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
               imm_i[4:1], imm_i[11], opcode_i};
        bad = !in_range(imm_i, ImmBMin, ImmBMax) || imm_i[0];
      end
      FmtU: begin
        raw = {imm_i[31:12], rd_i, opcode_i};
        bad = (imm_i[11:0] != 12'h000);
      end
      FmtJ: begin
        raw = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
               rd_i, opcode_i};
        bad = !in_range(imm_i, ImmJMin, ImmJMax) || imm_i[0];
      end
      default: ;
    endcase
    err_o  = bad;
    word_o = bad ? NOP : raw;
  end
endmodule

// File: rtl/instr_encode.sv
// Registered RV32I instruction encoder with valid/ready handshakes.
// ENCODE_PSEUDO_EN adds li expansion into a LUI/ADDI pair.
module instr_encode
  import riscv_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  instr_encode_if.slave  bus
);
`ifdef ENCODE_PSEUDO_EN
  typedef enum logic [1:0] {SIdle, SOut, SOutHi} state_e;
`else
  typedef enum logic [1:0] {SIdle, SOut} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic        ready, accept;

  logic [2:0]  pk_fmt;
  logic [6:0]  pk_op;
  logic [4:0]  pk_rd, pk_rs1;
  logic [2:0]  pk_f3;
  logic [31:0] pk_imm, pk_word;
  logic        pk_err;

`ifdef ENCODE_PSEUDO_EN
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic [11:0] pend_lo_q, pend_lo_d;
  logic [19:0] li_hi;
  logic        two_word;
`endif

  assign ready  = (state_q == SIdle) ||
                  (state_q == SOut && bus.ready_i);
  assign accept = bus.valid_i && ready;

  // Field source: the live request, or a synthesized LUI/ADDI.
  always_comb begin
    pk_fmt = bus.fmt_i;
    pk_op  = bus.opcode_i;
    pk_rd  = bus.rd_i;
    pk_rs1 = bus.rs1_i;
    pk_f3  = bus.funct3_i;
    pk_imm = bus.imm_i;
`ifdef ENCODE_PSEUDO_EN
    two_word = 1'b0;
    li_hi = bus.imm_i[31:12] + 20'(bus.imm_i[11]);
    if (state_q == SOutHi) begin
      pk_fmt = FmtI;
      pk_op  = OpImm;
      pk_rd  = pend_rd_q;
      pk_rs1 = pend_rd_q;
      pk_f3  = 3'd0;
      pk_imm = {{20{pend_lo_q[11]}}, pend_lo_q};
    end else if (bus.fmt_i == FmtLi) begin
      pk_rs1 = 5'd0;
      pk_f3  = 3'd0;
      if (li_hi == 20'd0) begin
        pk_fmt = FmtI;
        pk_op  = OpImm;
        pk_imm = {{20{bus.imm_i[11]}}, bus.imm_i[11:0]};
      end else begin
        pk_fmt   = FmtU;
        pk_op    = OpLui;
        pk_imm   = {li_hi, 12'h000};
        two_word = (bus.imm_i[11:0] != 12'h000);
      end
    end
`endif
  end

  instr_pack u_pack (
    .fmt_i    (pk_fmt),
    .opcode_i (pk_op),
    .rd_i     (pk_rd),
    .rs1_i    (pk_rs1),
    .rs2_i    (bus.rs2_i),
    .funct3_i (pk_f3),
    .funct7_i (bus.funct7_i),
    .imm_i    (pk_imm),
    .word_o   (pk_word),
    .err_o    (pk_err)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    last_d  = last_q;
    err_d   = err_q;
`ifdef ENCODE_PSEUDO_EN
    pend_rd_d = pend_rd_q;
    pend_lo_d = pend_lo_q;
`endif
    unique case (state_q)
      SIdle, SOut: begin
        if (accept) begin
          instr_d = pk_word;
          err_d   = pk_err;
          last_d  = 1'b1;
          state_d = SOut;
`ifdef ENCODE_PSEUDO_EN
          if (two_word) begin
            last_d    = 1'b0;
            state_d   = SOutHi;
            pend_rd_d = bus.rd_i;
            pend_lo_d = bus.imm_i[11:0];
          end
`endif
        end else if (state_q == SOut && bus.ready_i) begin
          state_d = SIdle;
        end
      end
`ifdef ENCODE_PSEUDO_EN
      SOutHi: begin
        if (bus.ready_i) begin
          instr_d = pk_word;
          err_d   = pk_err;
          last_d  = 1'b1;
          state_d = SOut;
        end
      end
`endif
      default: state_d = SIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SIdle;
      instr_q   <= 32'h0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef ENCODE_PSEUDO_EN
      pend_rd_q <= 5'd0;
      pend_lo_q <= 12'h0;
`endif
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      last_q    <= last_d;
      err_q     <= err_d;
`ifdef ENCODE_PSEUDO_EN
      pend_rd_q <= pend_rd_d;
      pend_lo_q <= pend_lo_d;
`endif
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = (state_q != SIdle);
  assign bus.instr_o = instr_q;
  assign bus.last_o  = last_q;
  assign bus.err_o   = err_q;
endmodule

// File: tb/tb_instr_encode.sv
// Self-checking bench for instr_encode: directed vectors plus a random
// stream scored against a behavioural encoder model.
module tb_instr_encode;
  import riscv_pkg::*;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct packed {
    logic [31:0] w;
    logic        last;
    logic        err;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encode_if bus();

  instr_encode dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  beat_t ovr[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic req_t rq(input logic [2:0] fmt, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
    return {fmt, op, rd, rs1, rs2, f3, f7, imm};
  endfunction

  // Reference encoder: arithmetic field placement from the ISA formats.
  function automatic void push_model(input req_t r);
    logic [31:0] op, rd, rs1, rs2, f3, f7, im, w;
    int s;
    bit ok;
    op = 32'(r.op); rd = 32'(r.rd); rs1 = 32'(r.rs1);
    rs2 = 32'(r.rs2); f3 = 32'(r.f3); f7 = 32'(r.f7);
    im = r.imm; s = int'($signed(r.imm)); ok = 1'b1; w = 32'h0;
    case (r.fmt)
      FmtR: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
              | (rd << 7) | op;
      FmtI: begin
        ok = (s >= -2048) && (s <= 2047);
        w = ((im & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12)
          | (rd << 7) | op;
      end
      FmtS: begin
        ok = (s >= -2048) && (s <= 2047);
        w = (((im >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15)
          | (f3 << 12) | ((im & 32'h1F) << 7) | op;
      end
      FmtB: begin
        ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25)
          | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7) | op;
      end
      FmtU: begin
        ok = (im & 32'hFFF) == 0;
        w = (im & 32'hFFFFF000) | (rd << 7) | op;
      end
      FmtJ: begin
        ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
          | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12)
          | (rd << 7) | op;
      end
      FmtLi: begin
`ifdef ENCODE_PSEUDO_EN
        logic [31:0] hi, lo;
        hi = (im + 32'h800) >> 12;
        lo = im & 32'hFFF;
        if (hi == 0) begin
          w = (lo << 20) | (rd << 7) | 32'h13;
        end else begin
          w = (hi << 12) | (rd << 7) | 32'h37;
          if (lo != 0) begin
            sb.push_back({w, 1'b0, 1'b0});
            w = (lo << 20) | (rd << 15) | (rd << 7) | 32'h13;
          end
        end
`else
        ok = 1'b0;
`endif
      end
      default: ok = 1'b0;
    endcase
    if (ok) sb.push_back({w, 1'b1, 1'b0});
    else    sb.push_back({32'h13, 1'b1, 1'b1});
  endfunction

  // One clock: drive at negedge, check outputs against scoreboard head.
  task automatic drive(input req_t r, input bit v, input bit rdy);
    bit ev, er;
    @(negedge clk);
    bus.valid_i  = v;
    bus.fmt_i    = r.fmt;
    bus.opcode_i = r.op;
    bus.rd_i     = r.rd;
    bus.rs1_i    = r.rs1;
    bus.rs2_i    = r.rs2;
    bus.funct3_i = r.f3;
    bus.funct7_i = r.f7;
    bus.imm_i    = r.imm;
    bus.ready_i  = rdy;
    #1;
    ev = (sb.size() != 0);
    er = (sb.size() == 0) || (sb.size() == 1 && rdy);
    chk("valid_o", 32'(bus.valid_o), 32'(ev));
    chk("ready_o", 32'(bus.ready_o), 32'(er));
    if (ev) begin
      chk("instr_o", bus.instr_o, sb[0].w);
      chk("last_o", 32'(bus.last_o), 32'(sb[0].last));
      chk("err_o", 32'(bus.err_o), 32'(sb[0].err));
      if (rdy) void'(sb.pop_front());
    end
    if (v && er) begin
      if (ovr.size() > 0) begin
        foreach (ovr[i]) sb.push_back(ovr[i]);
        ovr.delete();
      end else begin
        push_model(r);
      end
    end
  endtask

  task automatic drain();
    req_t z;
    z = '0;
    for (int i = 0; i < 6; i++) drive(z, 1'b0, 1'b1);
  endtask

  task automatic dir1(input req_t r, input logic [31:0] w, input bit e);
    ovr.push_back({w, 1'b1, e});
    drive(r, 1'b1, 1'b1);
    drain();
  endtask

  task automatic dir2(input req_t r, input logic [31:0] w0,
                      input logic [31:0] w1);
    ovr.push_back({w0, 1'b0, 1'b0});
    ovr.push_back({w1, 1'b1, 1'b0});
    drive(r, 1'b1, 1'b1);
    drain();
  endtask

  function automatic req_t rand_req();
    req_t r;
    int bnd[15] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                    1048574, -1048576, 1048576, 0, 32'h7FF, 32'h800,
                    32'hFFFFF800};
    r.fmt = 3'($urandom_range(0, 7));
    r.op  = 7'($urandom);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    r.f3  = 3'($urandom);
    r.f7  = 7'($urandom);
    case ($urandom_range(0, 5))
      0: r.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
      1: r.imm = $urandom;
      2: r.imm = $urandom & 32'hFFFFF000;
      3: r.imm = 32'(bnd[$urandom_range(0, 14)]);
      4: r.imm = 32'(int'($urandom_range(0, 1048575)) * 2 - 1048576);
      default: r.imm = 32'($urandom_range(0, 4095));
    endcase
    return r;
  endfunction

  initial begin
    req_t z;
    z = '0;
    bus.valid_i = 1'b0; bus.fmt_i = '0; bus.opcode_i = '0;
    bus.rd_i = '0; bus.rs1_i = '0; bus.rs2_i = '0;
    bus.funct3_i = '0; bus.funct7_i = '0; bus.imm_i = '0;
    bus.ready_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_instr", bus.instr_o, 32'd0);
    chk("rst_last", 32'(bus.last_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    dir1(rq(FmtR, 7'h33, 3, 1, 2, 0, 0, 0), 32'h002081B3, 1'b0);
    dir1(rq(FmtI, 7'h13, 1, 0, 0, 0, 0, 32'hFFFFFFFF),
         32'hFFF00093, 1'b0);
    dir1(rq(FmtB, 7'h63, 0, 0, 0, 0, 0, 32'hFFFFFFFC),
         32'hFE000EE3, 1'b0);
    dir1(rq(FmtI, 7'h13, 1, 0, 0, 0, 0, 2047), 32'h7FF00093, 1'b0);
    dir1(rq(FmtB, 7'h63, 0, 0, 0, 0, 0, 4094), 32'h7E000FE3, 1'b0);
    dir1(rq(FmtJ, 7'h6F, 0, 0, 0, 0, 0, 32'hFFF00000),
         32'h8000006F, 1'b0);
    dir1(rq(FmtU, 7'h37, 1, 0, 0, 0, 0, 32'h12345000),
         32'h123450B7, 1'b0);
    dir1(rq(FmtI, 7'h13, 1, 0, 0, 0, 0, 2048), NOP, 1'b1);
    dir1(rq(FmtB, 7'h63, 0, 0, 0, 0, 0, 5), NOP, 1'b1);
    dir1(rq(FmtJ, 7'h6F, 0, 0, 0, 0, 0, 32'hFFEFFFFE), NOP, 1'b1);
    dir1(rq(FmtU, 7'h37, 1, 0, 0, 0, 0, 32'h12345001), NOP, 1'b1);
    dir1(rq(3'd7, 7'h13, 1, 0, 0, 0, 0, 0), NOP, 1'b1);
`ifdef ENCODE_PSEUDO_EN
    dir2(rq(FmtLi, 0, 5, 0, 0, 0, 0, 32'h12345FFF),
         32'h123462B7, 32'hFFF28293);
    dir2(rq(FmtLi, 0, 5, 0, 0, 0, 0, 32'h800),
         32'h000012B7, 32'h80028293);
`else
    dir1(rq(FmtLi, 0, 5, 0, 0, 0, 0, 32'h12345FFF), NOP, 1'b1);
`endif

    // Back-to-back single-word requests, then a 3-cycle stall.
    drive(rq(FmtR, 7'h33, 3, 1, 2, 0, 0, 0), 1'b1, 1'b1);
    drive(rq(FmtI, 7'h13, 1, 0, 0, 0, 0, 5), 1'b1, 1'b1);
    drain();
    ovr.push_back({32'h002081B3, 1'b1, 1'b0});
    drive(rq(FmtR, 7'h33, 3, 1, 2, 0, 0, 0), 1'b1, 1'b1);
    repeat (3) drive(z, 1'b0, 1'b0);
    drain();

    // Reset while the first li word is held.
    drive(rq(FmtLi, 0, 5, 0, 0, 0, 0, 32'h12345FFF), 1'b1, 1'b0);
    drive(z, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.valid_o), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    dir1(rq(FmtI, 7'h13, 1, 0, 0, 0, 0, 32'hFFFFFFFF),
         32'hFFF00093, 1'b0);

    for (int n = 0; n < 400; n++)
      drive(rand_req(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 3) != 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
